uart_rx: RTL and testbench

Oversampling UART receiver that recovers frames produced by the TX_UART serial output and presents them as parallel words to the ALU-side logic. It detects the start bit, majority-votes three mid-bit samples per bit, and checks optional parity and the stop bit. For each frame it reports either a one-cycle data-valid strobe or error strobes. It runs on the oversampled clock, which is Prescale times the transmitter bit clock.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial line, per-frame configuration and receive results of uart_rx.
// master drives the line and configuration; slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, Prescale, parity_enable, parity_type,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, Prescale, parity_enable, parity_type,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detect, 3-sample majority vote, parity/stop check.
// Strobes one cycle after the stop-bit decision (frame cycle N); no backpressure, line is free-running.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave rx
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [5:0]            p_lat;
    logic                  pe_lat;
    logic                  pt_lat;
    logic [5:0]            edge_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic                  armed;
    logic [2:0]            samples;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bad;

    logic [5:0]            half;
    logic                  bit_end;
    logic                  vote;
    logic                  start_det;
    logic                  last_data;
    logic                  frame_done;

    // Anything other than 16 or 32 runs as 8x oversampling.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            6'd16:   return 6'd16;
            6'd32:   return 6'd32;
            default: return 6'd8;
        endcase
    endfunction

    assign half       = p_lat >> 1;
    assign bit_end    = (edge_cnt == p_lat - 6'd1);
    assign vote       = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);
    assign start_det  = (state == IDLE) && armed && !rx.RX_IN;
    assign last_data  = (bit_cnt == BCW'(DATA_WIDTH - 1));
    assign frame_done = (state == STOP) && bit_end;
    assign rx.busy    = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_det) state_nxt = START;
            end
            START: begin
                if (bit_end) state_nxt = vote ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && last_data) state_nxt = pe_lat ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The start-detect cycle is edge 0, so the counter leaves IDLE already at 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (state == IDLE) begin
            edge_cnt <= start_det ? 6'd1 : 6'd0;
        end else if (bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_lat  <= 6'd8;
            pe_lat <= 1'b0;
            pt_lat <= 1'b0;
        end else if (start_det) begin
            p_lat  <= legal_prescale(rx.Prescale);
            pe_lat <= rx.parity_enable;
            pt_lat <= rx.parity_type;
        end
    end

    // A line held low through reset must go high once before a start is believed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            armed <= 1'b0;
        end else if (rx.RX_IN) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= '0;
        end else if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) samples[0] <= rx.RX_IN;
            if (edge_cnt == half)        samples[1] <= rx.RX_IN;
            if (edge_cnt == half + 6'd1) samples[2] <= rx.RX_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (start_det) par_bad <= 1'b0;
                end
                DATA: begin
                    if (bit_end) begin
                        shift[bit_cnt] <= vote;
                        bit_cnt        <= bit_cnt + BCW'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) par_bad <= (vote != ((^shift) ^ pt_lat));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx.P_DATA     <= '0;
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
        end else begin
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
            if (frame_done) begin
                if (vote && !par_bad) begin
                    rx.data_valid <= 1'b1;
                    rx.P_DATA     <= shift;
                end else begin
                    rx.par_err <= par_bad;
                    rx.stp_err <= !vote;
                end
            end
        end
    end

    assert property (@(posedge CLK) disable iff (!RST)
        rx.data_valid |-> !(rx.par_err || rx.stp_err));

    assert property (@(posedge CLK) disable iff (!RST)
        (rx.data_valid || rx.par_err || rx.stp_err) |-> !rx.busy);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed frames against a frame-level reference model of uart_rx.
module tb_uart_rx;
    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();
    uart_rx #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .rx(bus));

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_p(input logic [5:0] pre);
        return (pre == 6'd16 || pre == 6'd32) ? int'(pre) : 8;
    endfunction

    // The bench always sits at a negedge: outputs show the current cycle, RX_IN is set for it.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.RX_IN = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input string tag, input logic [DW-1:0] data, input logic [5:0] pre,
                              input bit pe, input bit pt, input bit par_bit, input bit stop_bit,
                              input int glitch_bit, input int glitch_off);
        int   p;
        int   nbits;
        int   n;
        int   b;
        int   e;
        int   busy_bad;
        int   strb_bad;
        int   ones;
        bit   exp_pe;
        bit   exp_se;
        bit   exp_dv;
        logic lv;
        logic line [0:DW+3];
        p        = eff_p(pre);
        nbits    = 2 + DW + int'(pe);
        n        = nbits * p;
        busy_bad = 0;
        strb_bad = 0;
        line[0]  = 1'b0;
        for (int i = 0; i < DW; i++) line[1+i] = data[i];
        if (pe) line[1+DW] = par_bit;
        line[nbits-1] = stop_bit;
        for (int c = 0; c < n; c++) begin
            b  = c / p;
            e  = c % p;
            lv = line[b];
            if (b == glitch_bit && e == p / 2 + glitch_off) lv = ~lv;
            if (bus.busy !== (c != 0)) busy_bad++;
            if (c != 0 && (bus.data_valid || bus.par_err || bus.stp_err)) strb_bad++;
            if (c == 0) begin
                bus.Prescale      = pre;
                bus.parity_enable = pe;
                bus.parity_type   = pt;
            end else if (c == 1) begin
                bus.Prescale      = 6'($urandom_range(0, 63));
                bus.parity_enable = 1'($urandom_range(0, 1));
                bus.parity_type   = 1'($urandom_range(0, 1));
            end
            bus.RX_IN = lv;
            @(negedge CLK);
        end
        // Parity is good when the ones count over data+parity has the requested oddness.
        ones   = $countones(data) + int'(par_bit);
        exp_pe = pe && ((ones % 2) != int'(pt));
        exp_se = !stop_bit;
        exp_dv = !exp_pe && !exp_se;
        if (exp_dv) exp_data = data;
        chk({tag, ".busy_in_frame"}, 32'(busy_bad), 32'd0);
        chk({tag, ".quiet_in_frame"}, 32'(strb_bad), 32'd0);
        chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, ".data_valid"}, 32'(bus.data_valid), 32'(exp_dv));
        chk({tag, ".par_err"}, 32'(bus.par_err), 32'(exp_pe));
        chk({tag, ".stp_err"}, 32'(bus.stp_err), 32'(exp_se));
        chk({tag, ".P_DATA"}, 32'(bus.P_DATA), 32'(exp_data));
    endtask

    // Start bit that is low for only a few cycles at 8x must be rejected at cycle 8.
    task automatic start_glitch(input int low_cycles);
        int busy_bad;
        int strb_bad;
        busy_bad = 0;
        strb_bad = 0;
        bus.Prescale = 6'd8;
        for (int c = 0; c < 8; c++) begin
            if (bus.busy !== (c != 0)) busy_bad++;
            if (c != 0 && (bus.data_valid || bus.par_err || bus.stp_err)) strb_bad++;
            bus.RX_IN = (c < low_cycles) ? 1'b0 : 1'b1;
            @(negedge CLK);
        end
        chk("glitch.busy_1_7", 32'(busy_bad), 32'd0);
        chk("glitch.quiet", 32'(strb_bad), 32'd0);
        chk("glitch.idle_at_8", 32'(bus.busy), 32'd0);
        chk("glitch.no_strobe", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
        chk("glitch.P_DATA", 32'(bus.P_DATA), 32'(exp_data));
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [5:0]    rp;
        bit            rpe;
        bit            rpt;
        bit            rpb;
        bit            rst_bit;
        int            gb;
        int            go;
        int            bad;
        logic          line [0:DW+1];

        bus.RX_IN         = 1'b1;
        bus.Prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
        RST               = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset.P_DATA", 32'(bus.P_DATA), 32'd0);
        chk("reset.data_valid", 32'(bus.data_valid), 32'd0);
        chk("reset.par_err", 32'(bus.par_err), 32'd0);
        chk("reset.stp_err", 32'(bus.stp_err), 32'd0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        RST = 1'b1;
        idle(2);

        send_frame("p8_even_ok", 8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(3);
        send_frame("p8_even_bad", 8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
        idle(2);
        send_frame("p16_3C", 8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        send_frame("p16_C3", 8'hC3, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(1);
        send_frame("p8_stop0", 8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        send_frame("p8_after_stp", 8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(2);
        start_glitch(2);
        send_frame("after_glitch", 8'h96, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(2);
        send_frame("flip_d3_e4", 8'hB4, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0);
        idle(1);
        send_frame("odd_ok_p13", 8'h07, 6'd13, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rp = 6'd8;
                1: rp = 6'd16;
                2: rp = 6'd32;
                default: rp = 6'($urandom_range(0, 63));
            endcase
            rd  = DW'($urandom);
            rpe = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            rpb = 1'($urandom_range(0, 1));
            rst_bit = ($urandom_range(0, 5) != 0);
            gb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1 + DW + int'(rpe))) : -1;
            go  = int'($urandom_range(0, 2)) - 1;
            send_frame($sformatf("rnd%0d", i), rd, rp, rpe, rpt, rpb, rst_bit, gb, go);
            idle(int'($urandom_range(0, 3)));
        end

        // Abort a frame at cycle 40 with the line low, then hold it low through and after reset.
        bus.Prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        rd      = 8'h99;
        line[0] = 1'b0;
        for (int k = 0; k < DW; k++) line[1+k] = rd[k];
        line[DW+1] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.RX_IN = line[c / 8];
            @(negedge CLK);
        end
        bus.RX_IN = 1'b0;
        RST       = 1'b0;
        #1;
        exp_data = '0;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.strobes", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
        chk("midrst.P_DATA", 32'(bus.P_DATA), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            bus.RX_IN = 1'b0;
            @(negedge CLK);
            if (bus.busy || bus.data_valid || bus.par_err || bus.stp_err) bad++;
        end
        chk("low_after_rst.no_start", 32'(bad), 32'd0);
        idle(1);
        send_frame("after_arm", 8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
